// File: rtl/memory_controller_pkg.sv
// rtl/memory_controller_pkg.sv - shared encodings for the memory controller
package memory_controller_pkg;

  localparam logic READ    = 1'b0;
  localparam logic WRITE   = 1'b1;
  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam int WORD_BITS   = 32;
  localparam int COUNT_BITS  = 4;
  localparam int MAX_LATENCY = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2,
    HOLD = 2'd3
  } state_t;

endpackage

// File: rtl/memory_controller_if.sv
// rtl/memory_controller_if.sv - core-to-controller request/response bundle
interface memory_controller_if;

  logic        memoryEnable;
  logic        memoryReadWrite;
  logic [31:0] memoryAddress;
  logic [31:0] memoryWriteData;
  logic [31:0] memoryData;
  logic        memoryReady;
  logic        memoryError;

  modport master (
    output memoryEnable, memoryReadWrite, memoryAddress, memoryWriteData,
    input  memoryData, memoryReady, memoryError
  );

  modport slave (
    input  memoryEnable, memoryReadWrite, memoryAddress, memoryWriteData,
    output memoryData, memoryReady, memoryError
  );

endinterface

// File: rtl/memory_controller_array.sv
// rtl/memory_controller_array.sv - single-port word store with registered, write-first read port
module memory_array #(
  parameter int DEPTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             we,
  input  logic [DEPTH-1:0] addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [0:(1<<DEPTH)-1];

  // Storage has no reset so contents survive a controller reset.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

  // The read register doubles as the controller's data output, so a write
  // also returns its own data and idle cycles leave it untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
    end else if (en) begin
      rdata <= we ? wdata : mem[addr];
    end
  end

endmodule

// File: rtl/memory_controller.sv
// rtl/memory_controller.sv - fixed-latency request/ready memory controller
// Optional alignment checking: MEMORY_CONTROLLER_ALIGN_CHECK_EN
module memory_controller
  import memory_controller_pkg::*;
#(
  parameter int DEPTH   = 10,
  parameter int LATENCY = 2
) (
  input logic                clk,
  input logic                reset,
  memory_controller_if.slave bus
);

  localparam logic [COUNT_BITS-1:0] LAT_LOAD = COUNT_BITS'(LATENCY - 1);

  state_t                state;
  state_t                nextState;
  logic [COUNT_BITS-1:0] counter;
  logic [DEPTH-1:0]      addrReg;
  logic                  rwReg;
  logic [31:0]           wdataReg;
  logic                  readyReg;
  logic                  errorReg;
  logic                  accept;
  logic                  accessDone;
  logic                  misaligned;
  logic [31:0]           arrayData;
  logic                  unusedAddr;

  assign accept     = (state == IDLE) && (bus.memoryEnable == ENABLE);
  assign accessDone = (state == WAIT) && (bus.memoryEnable == ENABLE) && (counter == '0);

  // Only the word index is ever used; byte offset and bits above the array wrap away.
  assign unusedAddr = ^{bus.memoryAddress[31:DEPTH+2], bus.memoryAddress[1:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (bus.memoryEnable == ENABLE) nextState = WAIT;
      WAIT: begin
        // Dropping enable mid-flight abandons the access entirely.
        if (bus.memoryEnable != ENABLE) nextState = IDLE;
        else if (counter == '0)         nextState = DONE;
      end
      DONE: nextState = (bus.memoryEnable == ENABLE) ? HOLD : IDLE;
      HOLD: if (bus.memoryEnable != ENABLE) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      counter  <= '0;
      addrReg  <= '0;
      rwReg    <= READ;
      wdataReg <= '0;
      readyReg <= 1'b0;
      errorReg <= 1'b0;
    end else begin
      if (accept) begin
        counter  <= LAT_LOAD;
        addrReg  <= bus.memoryAddress[DEPTH+1:2];
        rwReg    <= bus.memoryReadWrite;
        wdataReg <= bus.memoryWriteData;
      end else if (state == WAIT && counter != '0) begin
        counter <= counter - 1'b1;
      end
      readyReg <= accessDone;
      errorReg <= accessDone && misaligned;
    end
  end

`ifdef MEMORY_CONTROLLER_ALIGN_CHECK_EN
  logic misalignReg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      misalignReg <= 1'b0;
    end else if (accept) begin
      misalignReg <= (bus.memoryAddress[1:0] != 2'b00);
    end
  end

  assign misaligned = misalignReg;
`else
  assign misaligned = 1'b0;
`endif

  // A misaligned request still completes on time but never touches the array.
  memory_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .en    (accessDone && !misaligned),
    .we    (rwReg == WRITE),
    .addr  (addrReg),
    .wdata (wdataReg),
    .rdata (arrayData)
  );

  assign bus.memoryData  = arrayData;
  assign bus.memoryReady = readyReg;
  assign bus.memoryError = errorReg;

endmodule

// File: tb/tb_memory_controller.sv
// tb/tb_memory_controller.sv - randomized scoreboard bench for memory_controller
module tb_memory_controller;
  import memory_controller_pkg::*;

  localparam int DEPTH   = 10;
  localparam int LATENCY = 2;
  localparam int WORDS   = 1 << DEPTH;
`ifdef MEMORY_CONTROLLER_ALIGN_CHECK_EN
  localparam bit ALIGN_CHECK = 1'b1;
`else
  localparam bit ALIGN_CHECK = 1'b0;
`endif

  typedef struct {
    logic [31:0] data;
    bit          checkData;
    bit          err;
    int          acceptCycle;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   vectors = 0;
  int   fails = 0;

  exp_t        expQ[$];
  logic [31:0] refMem[int];
  logic [31:0] lastData;
  bit          lastKnown;

  memory_controller_if bus();

  memory_controller #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Every ready pulse must correspond to exactly one outstanding expectation.
  always @(negedge clk) begin
    if (reset && bus.memoryReady) begin
      if (expQ.size() == 0) begin
        check("unexpected_ready", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        check("latency", 32'(cyc - e.acceptCycle), 32'(LATENCY));
        check("error", {31'd0, bus.memoryError}, {31'd0, e.err});
        if (e.checkData) check("data", bus.memoryData, e.data);
      end
    end
  end

  task automatic doAccess(input logic rw, input logic [31:0] addr, input logic [31:0] wd, input int hold);
    exp_t e;
    int   idx;
    int   n;
    bit   mis;
    idx = int'((addr >> 2) % 32'(WORDS));
    mis = ALIGN_CHECK && (addr[1:0] != 2'b00);
    @(posedge clk); #1;
    bus.memoryEnable    = ENABLE;
    bus.memoryReadWrite = rw;
    bus.memoryAddress   = addr;
    bus.memoryWriteData = wd;
    @(posedge clk); #1;
    e.acceptCycle = cyc;
    e.err = mis;
    if (mis) begin
      e.data = lastData;
      e.checkData = lastKnown;
    end else if (rw == WRITE) begin
      refMem[idx] = wd;
      e.data = wd;
      e.checkData = 1'b1;
      lastData = wd;
      lastKnown = 1'b1;
    end else if (refMem.exists(idx)) begin
      e.data = refMem[idx];
      e.checkData = 1'b1;
      lastData = e.data;
      lastKnown = 1'b1;
    end else begin
      e.data = '0;
      e.checkData = 1'b0;
      lastKnown = 1'b0;
    end
    expQ.push_back(e);
    // Inputs other than enable are free to change once the request is taken.
    bus.memoryReadWrite = 1'($urandom);
    bus.memoryAddress   = $urandom;
    bus.memoryWriteData = $urandom;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.memoryReady && n < 20);
    check("ready_seen", {31'd0, bus.memoryReady}, 32'd1);
    repeat (hold) @(negedge clk);
    bus.memoryEnable = DISABLE;
  endtask

  task automatic doAbort(input logic [31:0] addr, input logic [31:0] wd, input bit useReset);
    @(posedge clk); #1;
    bus.memoryEnable    = ENABLE;
    bus.memoryReadWrite = WRITE;
    bus.memoryAddress   = addr;
    bus.memoryWriteData = wd;
    @(posedge clk); #1;
    bus.memoryEnable = DISABLE;
    if (useReset) begin
      reset = 1'b0;
      #1;
      check("reset_wait_ready", {31'd0, bus.memoryReady}, 32'd0);
      check("reset_wait_data", bus.memoryData, 32'd0);
      #2;
      reset = 1'b1;
      lastData = '0;
      lastKnown = 1'b1;
    end
    repeat (LATENCY + 3) @(negedge clk);
    if (lastKnown) check("abort_data_hold", bus.memoryData, lastData);
  endtask

  initial begin
    reset = 1'b0;
    bus.memoryEnable    = DISABLE;
    bus.memoryReadWrite = READ;
    bus.memoryAddress   = '0;
    bus.memoryWriteData = '0;
    lastData  = '0;
    lastKnown = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_ready", {31'd0, bus.memoryReady}, 32'd0);
    check("reset_error", {31'd0, bus.memoryError}, 32'd0);
    check("reset_data", bus.memoryData, 32'd0);
    reset = 1'b1;

    doAccess(WRITE, 32'h0000_0000, 32'h0050_0093, 0);
    doAccess(READ,  32'h0000_0000, 32'h0, 0);
    doAccess(WRITE, 32'h0000_0010, 32'hDEAD_BEEF, 0);
    doAccess(READ,  32'h0000_0010, 32'h0, 0);
    doAccess(READ,  32'h0000_1000, 32'h0, 0);
    doAccess(WRITE, 32'h0000_0020, 32'h1111_2222, 0);
    doAbort(32'h0000_0020, 32'h3333_4444, 1'b0);
    doAccess(READ,  32'h0000_0020, 32'h0, 0);
    doAbort(32'h0000_0020, 32'h5555_6666, 1'b1);
    doAccess(READ,  32'h0000_0020, 32'h0, 0);
    doAccess(READ,  32'h0000_0010, 32'h0, 5);
    doAccess(WRITE, 32'h0000_0004, 32'hCAFE_F00D, 0);
    doAccess(READ,  32'h0000_0010, 32'h0, 0);
    doAccess(READ,  32'h0000_0006, 32'h0, 0);
    doAccess(WRITE, 32'h0000_0005, 32'h0BAD_0BAD, 0);
    doAccess(READ,  32'h0000_0004, 32'h0, 0);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      int          kind;
      a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2);
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
      kind = int'($urandom_range(0, 7));
      if (kind == 0) doAbort(a, $urandom, 1'b0);
      else doAccess(1'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(0, 2)));
    end

    repeat (4) @(negedge clk);
    check("queue_drained", 32'(expQ.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/memory_controller.md
MEMORY_CONTROLLER -- requirements
Module: memory_controller

Interface
REQ-001 Parameter DEPTH, default 10, SHALL set the word-address width; array size is 2^DEPTH 32-bit words.
REQ-002 Parameter LATENCY, default 2, SHALL set the request-to-ready delay in cycles; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 memoryEnable  input  1  request valid; held high by the core until ready is seen.
REQ-006 memoryReadWrite  input  1  `READ or `WRITE, per Defines.v encoding.
REQ-007 memoryAddress  input  32  byte address.
REQ-008 memoryWriteData  input  32  store data.
REQ-009 memoryData  output  32  registered read data.
REQ-010 memoryReady  output  1  registered, one-cycle completion pulse.
REQ-011 memoryError  output  1  registered misalignment flag; valid only with memoryReady.

Function
REQ-012 FSM states: IDLE, WAIT, DONE, HOLD.
REQ-013 IDLE: memoryEnable=1 at an edge latches address, direction and write data, loads counter with LATENCY-1, then goes to WAIT.
REQ-014 WAIT: at each edge, counter==0 performs the access and goes to DONE; otherwise the counter decrements.
REQ-015 memoryReady SHALL be 1 exactly while in DONE, i.e. after edge k+LATENCY, for a request sampled at edge k.
REQ-016 Read access: memoryData <= array[addr[DEPTH+1:2]] on the WAIT->DONE edge; it holds until the next completed access.
REQ-017 Write access: array[addr[DEPTH+1:2]] <= latched write data on the WAIT->DONE edge; memoryData <= latched write data.
REQ-018 Addresses above the array size SHALL wrap: upper bits are ignored.
REQ-019 DONE lasts one cycle, then goes to HOLD if memoryEnable=1, else to IDLE.
REQ-020 HOLD: no new request is accepted; the FSM goes to IDLE on the first edge with memoryEnable=0.
REQ-021 If memoryEnable drops during WAIT, the request SHALL abort: return to IDLE, no array write, no ready pulse.
REQ-022 Input changes after acceptance SHALL NOT affect the in-flight access.
REQ-023 Back-to-back throughput: at least one idle cycle (memoryEnable low) is required between requests.

Reset
REQ-024 reset low SHALL asynchronously force state=IDLE, counter=0, memoryReady=0, memoryError=0 and memoryData=0.
REQ-025 Array contents SHALL NOT be cleared by reset.
REQ-026 Reset during WAIT SHALL cancel the access with no array write.

Configuration
REQ-027 With MEMORY_CONTROLLER_ALIGN_CHECK_EN defined, a request with addr[1:0]!=0 SHALL still complete after LATENCY cycles.
REQ-028 In that case memoryError=1 with the ready pulse, there is no array write, and memoryData is unchanged.
REQ-029 Without MEMORY_CONTROLLER_ALIGN_CHECK_EN, addr[1:0] SHALL be ignored and memoryError SHALL be tied to 0.

Structure
REQ-030 `READ/`WRITE, `ENABLE/`DISABLE and the FSM state encodings SHALL live in shared Defines.v.
REQ-031 Storage SHALL be one sub-module, memory_array: synchronous single-port, one write enable, registered read.

Verification
REQ-032 Reset, then read address 0x0 with LATENCY=2 and preloaded word 0x00500093 -> memoryReady high exactly 2 cycles after acceptance, memoryData=0x00500093.
REQ-033 Write 0xDEADBEEF to 0x10, drop enable, then read 0x10 -> second access returns 0xDEADBEEF.
REQ-034 Hold enable high for 5 cycles after ready -> single ready pulse, no second access until enable has been low.
REQ-035 Drop enable in WAIT during a write to 0x20, then read 0x20 -> old value; reset pulsed mid-WAIT -> ready never asserts.
REQ-036 Read address 0x0000_1000 with DEPTH=10 -> returns the word at 0x0 (wrap).
REQ-037 With the macro, read 0x6 -> memoryError=1 with ready and no write; without the macro -> the word at 0x4, error=0.
